// File: rtl/usb_cdc_pkg.sv
// Shared types and widths for the CDC stream buffer: byte type, statistics
// counter widths and the TX pacing FSM states.
package usb_cdc_pkg;

    typedef logic [7:0] byte_t;

    localparam int STAT_BYTES_W = 32;
    localparam int STAT_DROP_W  = 16;

    typedef enum logic {
        IDLE,
        BURST
    } tx_state_t;

endpackage

// File: rtl/usb_cdc_sync_fifo.sv
// Show-ahead synchronous byte FIFO with occupancy count and synchronous clear.
// Writes are not gated internally; the caller guarantees space (or a same-cycle pop).
module usb_cdc_sync_fifo
    import usb_cdc_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   wr_en,
    input  byte_t                  wr_data,
    input  logic                   rd_en,
    output byte_t                  rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    byte_t mem [DEPTH];
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;

    // Pointers carry one extra bit so full and empty differ without a flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/usb_cdc_stream_buf.sv
// CDC data-channel buffer: paced TX bursts towards the bulk IN endpoint and a
// backpressured RX queue from bulk OUT. Statistics built only with USB_CDC_BUF_STATS_EN.
module usb_cdc_stream_buf
    import usb_cdc_pkg::*;
#(
    parameter int TX_DEPTH      = 64,
    parameter int RX_DEPTH      = 64,
    parameter int MAX_PKT       = 32,
    parameter int FLUSH_TIMEOUT = 60000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    usb_rstn,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic                    tx_flush,
    output logic [7:0]              ep_in_data,
    output logic                    ep_in_valid,
    input  logic                    ep_in_ready,
    input  logic [7:0]              ep_out_data,
    input  logic                    ep_out_valid,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    rx_overflow,
    output logic [STAT_BYTES_W-1:0] stat_tx_bytes,
    output logic [STAT_BYTES_W-1:0] stat_rx_bytes,
    output logic [STAT_DROP_W-1:0]  stat_rx_drop
);

    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam int BW  = $clog2(MAX_PKT + 1);
    localparam int TW  = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TCW-1:0] MAX_PKT_C = TCW'(MAX_PKT);
    localparam logic [TW-1:0]  TIMEOUT_C = TW'(FLUSH_TIMEOUT);

    tx_state_t      state;
    logic           run_q;
    logic [BW-1:0]  burst_cnt;
    logic [TW-1:0]  timer;
    logic [TCW-1:0] tx_count;
    logic [RCW-1:0] rx_count;
    byte_t          tx_head;
    byte_t          rx_head;
    logic           tx_wr, tx_pop, tx_has_data, tx_full, start_burst;
    logic           rx_wr, rx_pop, rx_full, rx_drop;

    // Holds tx_ready low while rstn is asserted even though the FIFO is empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            run_q <= 1'b0;
        else
            run_q <= 1'b1;
    end

    assign tx_full     = tx_count[TCW-1];
    assign tx_has_data = (tx_count != '0);
    assign tx_ready    = run_q & usb_rstn & ~tx_full;
    assign tx_wr       = tx_valid & tx_ready;
    assign ep_in_valid = (state == BURST);
    assign ep_in_data  = ep_in_valid ? tx_head : 8'h00;
    assign tx_pop      = ep_in_valid & ep_in_ready & usb_rstn;
    assign start_burst = (tx_count >= MAX_PKT_C) ||
                         (tx_has_data && (tx_flush || timer == TIMEOUT_C));

    usb_cdc_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (~usb_rstn),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .count   (tx_count)
    );

    // Burst length is latched on entry so bytes written mid-burst wait for the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            burst_cnt <= '0;
            timer     <= '0;
        end else if (!usb_rstn) begin
            state     <= IDLE;
            burst_cnt <= '0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_burst) begin
                        state     <= BURST;
                        burst_cnt <= (tx_count >= MAX_PKT_C) ? BW'(MAX_PKT) : BW'(tx_count);
                    end
                    if (tx_wr)
                        timer <= '0;
                    else if (tx_has_data && timer != TIMEOUT_C)
                        timer <= timer + TW'(1);
                end
                BURST: begin
                    if (tx_wr)
                        timer <= '0;
                    if (tx_pop) begin
                        burst_cnt <= burst_cnt - BW'(1);
                        if (burst_cnt == BW'(1)) begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_valid = (rx_count != '0);
    assign rx_full  = rx_count[RCW-1];
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_wr    = ep_out_valid & usb_rstn & (~rx_full | rx_pop);
    assign rx_drop  = ep_out_valid & usb_rstn & rx_full & ~rx_pop;
    assign rx_data  = rx_valid ? rx_head : 8'h00;

    usb_cdc_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (~usb_rstn),
        .wr_en   (rx_wr),
        .wr_data (ep_out_data),
        .rd_en   (rx_pop),
        .rd_data (rx_head),
        .count   (rx_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rx_overflow <= 1'b0;
        else if (rx_drop)
            rx_overflow <= 1'b1;
    end

`ifdef USB_CDC_BUF_STATS_EN
    logic [STAT_BYTES_W-1:0] tx_bytes_q;
    logic [STAT_BYTES_W-1:0] rx_bytes_q;
    logic [STAT_DROP_W-1:0]  drop_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_bytes_q <= '0;
            rx_bytes_q <= '0;
            drop_q     <= '0;
        end else begin
            if (tx_pop)
                tx_bytes_q <= tx_bytes_q + STAT_BYTES_W'(1);
            if (rx_wr)
                rx_bytes_q <= rx_bytes_q + STAT_BYTES_W'(1);
            if (rx_drop && drop_q != '1)
                drop_q <= drop_q + STAT_DROP_W'(1);
        end
    end

    assign stat_tx_bytes = tx_bytes_q;
    assign stat_rx_bytes = rx_bytes_q;
    assign stat_rx_drop  = drop_q;
`else
    assign stat_tx_bytes = '0;
    assign stat_rx_bytes = '0;
    assign stat_rx_drop  = '0;
`endif

endmodule

// File: doc/usb_cdc_stream_buf.md
# usb_cdc_stream_buf

Buffering and packet-pacing layer between a user byte stream and one bulk IN / bulk OUT endpoint pair of the USB full-speed core. The TX path queues device-to-host bytes and releases them to the core in bursts of at most MAX_PKT bytes, either when a full packet has accumulated, on an idle timeout, or on an explicit flush. The RX path adds backpressure to the core's valid-only OUT stream, with drop accounting. One instance is used per CDC data channel; the core is instantiated by the parent.

## Interface
- TX_DEPTH, 64: TX FIFO depth in bytes; power of two, ≥ MAX_PKT.
- RX_DEPTH, 64: RX FIFO depth in bytes; power of two, ≥ 2.
- MAX_PKT, 32: maximum burst length offered to the core per release; 1..TX_DEPTH.
- FLUSH_TIMEOUT, 60000: idle clocks before a partial packet is released (1 ms at 60 MHz); ≥ 1.

Ports:
- clk  in  1  60 MHz clock.
- rstn  in  1  asynchronous active-low reset.
- usb_rstn  in  1  core link status; 0 = disconnected.
- tx_data  in  8  user byte to send.
- tx_valid  in  1  user byte valid.
- tx_ready  out  1  TX FIFO not full.
- tx_flush  in  1  single-cycle pulse: release buffered bytes immediately.
- ep_in_data  out  8  byte to core IN endpoint.
- ep_in_valid  out  1  byte offered to core.
- ep_in_ready  in  1  core accepts byte.
- ep_out_data  in  8  byte from core OUT endpoint.
- ep_out_valid  in  1  single-cycle strobe; no backpressure is possible.
- rx_data  out  8  received byte (FIFO head).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  user consumes byte.
- rx_overflow  out  1  sticky flag: an OUT byte was dropped.
- stat_tx_bytes  out  32  bytes handed to the core.
- stat_rx_bytes  out  32  bytes accepted into the RX FIFO.
- stat_rx_drop  out  16  dropped OUT bytes; saturates at 0xFFFF.

## Operation
- **Reset values:** every output is 0 under reset, including tx_ready. Both FIFOs are empty, the FSM is IDLE, and the timer is 0.
- **Link down:** while usb_rstn = 0, both FIFOs are cleared synchronously, the FSM is forced to IDLE, the timer is cleared, and tx_ready = 0. rx_overflow and the stats are held. Link loss mid-burst discards the rest of the burst.
- **TX write:** a byte is accepted when tx_valid and tx_ready are both high. There is no same-cycle full bypass: a full FIFO is not written even if it is being read in that cycle.
- **TX FSM, IDLE → BURST** on any of:
  - count ≥ MAX_PKT;
  - timer == FLUSH_TIMEOUT with count > 0;
  - tx_flush with count > 0 (tx_flush with an empty FIFO is ignored).
- **Entering BURST:** burst_cnt = min(count, MAX_PKT).
- **BURST:**
  - ep_in_valid = 1 and ep_in_data = FIFO head (show-ahead read).
  - Each ep_in_valid & ep_in_ready pops one byte and decrements burst_cnt.
  - When burst_cnt reaches 0, return to IDLE and clear the timer.
  - Writes that arrive during BURST are not added to the current burst.
  - tx_flush is ignored in BURST.
- **Timer:** counts only in IDLE with count > 0. It clears on every accepted tx write, and saturates at FLUSH_TIMEOUT.
- **RX:**
  - An ep_out_valid byte is written when the RX FIFO is not full, or when it is full and rx_ready & rx_valid pop in the same cycle.
  - Otherwise the byte is dropped: rx_overflow is set and stat_rx_drop increments.
- **rx_overflow** clears only on rstn.
- **Counters:** FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. The occupancy count is the pointer difference.

## Timing
- ep_in_valid rises one cycle after the trigger condition; the FSM transition is registered.
- Back-to-back: one byte per cycle while ep_in_ready is high.
- tx_ready drops in the cycle after the write that fills the FIFO.
- RX latency: a byte strobed on cycle n appears on rx_data/rx_valid at n+1.
- Timeout release: ep_in_valid rises FLUSH_TIMEOUT+1 cycles after the last accepted write.

## Configuration
- **USB_CDC_BUF_STATS_EN** defined: stat_tx_bytes and stat_rx_bytes are free-running wrapping counters; stat_rx_drop is a saturating counter.
- **Not defined:** all three stat outputs are tied to 0 and no counter flops are built. rx_overflow is always present.

## Structure
- **Shared package usb_cdc_pkg:**
  - byte type;
  - the STATS width localparams (32, 16);
  - the TX FSM state enum (IDLE, BURST).
- **Sub-module usb_cdc_sync_fifo:** parametrised depth, show-ahead output, count output, synchronous clear input. Instantiated twice, once for TX and once for RX.

## Test plan
- **Full-packet release:** write 32 bytes 0x00..0x1F with ep_in_ready = 1 → one burst of exactly 32 bytes in order, ep_in_valid high for 32 cycles, then IDLE.
- **Timeout release:** write 5 bytes, then idle → ep_in_valid rises exactly 60001 cycles after the 5th write; 5 bytes out, then ep_in_valid = 0.
- **Flush and backpressure:**
  - write 3 bytes, pulse tx_flush, toggle ep_in_ready every other cycle → 3 bytes out over 6 cycles;
  - tx_flush with an empty FIFO → no ep_in_valid.
- **RX overflow:**
  - hold rx_ready = 0 and strobe 65 bytes → the first 64 are retained, the 65th is dropped, rx_overflow = 1, stat_rx_drop = 1;
  - the full-with-simultaneous-pop case accepts the byte.
- **Link drop mid-burst:** usb_rstn = 0 after 10 of 32 bytes → ep_in_valid = 0 the next cycle, both FIFOs empty, tx_ready = 0 until usb_rstn = 1.
- **Async reset:** assert rstn mid-traffic, asynchronous to clk → all outputs 0 immediately.
